// File: rtl/cycle_sequencer_pkg.sv
// Shared types and constants for the CPU control path: FSM state encodings,
// ARM condition codes and the bit positions of the CPSR flags.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_READ  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cycle_sequencer_if.sv
// Control bundle between the cycle sequencer (master) and the datapath blocks
// it steers (slave): decoded instruction fields in, phase enables out.
interface cycle_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             halt;
    logic [3:0]       cond_field;
    logic [3:0]       cpsr;
    logic             is_mem;
    logic             is_branch;
    logic             is_link;
    logic             set_flags;
    logic             mem_ready;

    logic             instruction_en;
    logic             read_en;
    logic             ldr_str_en;
    logic             write_en;
    logic             cpsr_we;
    logic             pc_load;
    logic             br_taken;
    logic             r14_write;
    logic             mem_err;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] annulled_cnt;

    modport master (
        input  halt, cond_field, cpsr, is_mem, is_branch, is_link, set_flags, mem_ready,
        output instruction_en, read_en, ldr_str_en, write_en, cpsr_we, pc_load,
               br_taken, r14_write, mem_err, state_dbg, retired_cnt, annulled_cnt
    );

    modport slave (
        output halt, cond_field, cpsr, is_mem, is_branch, is_link, set_flags, mem_ready,
        input  instruction_en, read_en, ldr_str_en, write_en, cpsr_we, pc_load,
               br_taken, r14_write, mem_err, state_dbg, retired_cnt, annulled_cnt
    );
endinterface

// File: rtl/cycle_sequencer_cond_eval.sv
// Combinational ARM condition-field check against the CPSR flags {N,Z,C,V}.
// Code 4'hF (the old NV slot) never passes.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond_field,
    input  logic [3:0] cpsr,
    output logic       pass
);
    logic n, z, c, v;

    assign n = cpsr[FLAG_N];
    assign z = cpsr[FLAG_Z];
    assign c = cpsr[FLAG_C];
    assign v = cpsr[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond_field)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle FETCH/READ/MEM/WB control FSM with condition annulment and a
// bounded data-memory wait. Perf counters are built only with CYCLE_SEQ_PERF_EN.
module cycle_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 4,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    cycle_sequencer_if.master  bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_MAX);

    state_t     state_reg, state_next;
    logic       cond_pass_reg, cond_pass_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       cond_ok;

    cond_eval u_cond_eval (
        .cond_field (bus.cond_field),
        .cpsr       (bus.cpsr),
        .pass       (cond_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RESET;
            cond_pass_reg <= 1'b0;
            wait_cnt_reg  <= 4'd0;
        end else begin
            state_reg     <= state_next;
            cond_pass_reg <= cond_pass_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cond_pass_next = cond_pass_reg;
        wait_cnt_next  = wait_cnt_reg;
        case (state_reg)
            ST_RESET: state_next = ST_FETCH;
            ST_FETCH: state_next = ST_READ;
            ST_READ: begin
                cond_pass_next = cond_ok;
                wait_cnt_next  = 4'd1;
                state_next     = (bus.is_mem && cond_ok) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // A completion arriving on the limit cycle still counts.
                if (bus.mem_ready) begin
                    state_next = ST_WB;
                end else if (wait_cnt_reg >= WAIT_LIMIT) begin
                    state_next = ST_ERR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_WB:   state_next = bus.halt ? ST_HALT : ST_FETCH;
            ST_HALT: state_next = ST_HALT;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_RESET;
        endcase
    end

    always_comb begin
        bus.instruction_en = 1'b0;
        bus.read_en        = 1'b0;
        bus.ldr_str_en     = 1'b0;
        bus.write_en       = 1'b0;
        bus.cpsr_we        = 1'b0;
        bus.pc_load        = 1'b0;
        bus.br_taken       = 1'b0;
        bus.r14_write      = 1'b0;
        case (state_reg)
            ST_FETCH: bus.instruction_en = 1'b1;
            ST_READ:  bus.read_en        = 1'b1;
            ST_MEM:   bus.ldr_str_en     = 1'b1;
            ST_WB: begin
                bus.pc_load   = 1'b1;
                bus.write_en  = cond_pass_reg && !bus.is_branch;
                bus.cpsr_we   = cond_pass_reg && bus.set_flags;
                bus.br_taken  = cond_pass_reg && bus.is_branch;
                bus.r14_write = cond_pass_reg && bus.is_branch && bus.is_link;
            end
            default: ;
        endcase
    end

    // ERR is only left through reset, so the state itself is the sticky flag.
    assign bus.mem_err   = (state_reg == ST_ERR);
    assign bus.state_dbg = state_reg;

`ifdef CYCLE_SEQ_PERF_EN
    // Counter 0 tracks retired instructions, counter 1 annulled ones.
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [CNT_W-1:0] cnt_reg;
        logic             hit;

        assign hit = (state_reg == ST_WB) && (cond_pass_reg == (gi == 0));

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (hit && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
    assign bus.retired_cnt  = g_perf[0].cnt_reg;
    assign bus.annulled_cnt = g_perf[1].cnt_reg;
`else
    assign bus.retired_cnt  = '0;
    assign bus.annulled_cnt = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: a per-instruction model queues the
// expected output vector for every cycle and one process compares them.
module tb_cycle_sequencer;
    localparam int MAXW = 4;
    localparam int CW   = 8;

    typedef struct packed {
        logic [2:0]    st;
        logic [8:0]    en;   // {instr,read,ldr,write,cpsr_we,pc_load,br,r14,mem_err}
        logic [CW-1:0] ret;
        logic [CW-1:0] ann;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   m_ret = 0;
    int   m_ann = 0;
    int   cyc = 0, last_pl = 0, last_gap = 0, run = 0, last_run = 0;

    cycle_sequencer_if #(.CNT_W(CW)) bus ();

    cycle_sequencer #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pairs of codes share a base test; the odd member inverts it.
    function automatic bit m_cond(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return (cc == 4'hE);
        endcase
        return base ^ cc[0];
    endfunction

    function automatic exp_t mk(input logic [2:0] st, input logic [8:0] en);
        exp_t e;
        e.st = st;
        e.en = en;
`ifdef CYCLE_SEQ_PERF_EN
        e.ret = CW'(m_ret);
        e.ann = CW'(m_ann);
`else
        e.ret = '0;
        e.ann = '0;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t       e;
        logic [8:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.instruction_en, bus.read_en, bus.ldr_str_en, bus.write_en, bus.cpsr_we,
                   bus.pc_load, bus.br_taken, bus.r14_write, bus.mem_err};
            checks += 4;
            if (bus.state_dbg !== e.st) begin
                errors++;
                $display("FAIL state t=%0t got %0d want %0d", $time, bus.state_dbg, e.st);
            end
            if (act !== e.en) begin
                errors++;
                $display("FAIL enables t=%0t got %b want %b", $time, act, e.en);
            end
            if (bus.retired_cnt !== e.ret) begin
                errors++;
                $display("FAIL retired_cnt t=%0t got %0d want %0d", $time, bus.retired_cnt, e.ret);
            end
            if (bus.annulled_cnt !== e.ann) begin
                errors++;
                $display("FAIL annulled_cnt t=%0t got %0d want %0d", $time, bus.annulled_cnt, e.ann);
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (bus.pc_load === 1'b1) begin
            last_gap = cyc - last_pl;
            last_pl  = cyc;
        end
        if (bus.ldr_str_en === 1'b1) run++;
        else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
    end

    task automatic check_lit(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle_begin();
        m_ret = 0;
        m_ann = 0;
        exp_q.push_back(mk(3'd0, 9'b0));
        rst = 1'b0;
        $display("TXN reset");
    endtask

    task automatic do_instr(input string nm, input logic [3:0] cond, input logic [3:0] flags,
                            input bit mem, input bit br, input bit link, input bit sf,
                            input int ready_at, input bit hlt, input int rst_at);
        bit pass;
        pass = m_cond(cond, flags);
        cycle_begin();
        bus.cond_field = cond; bus.cpsr = flags; bus.is_mem = mem;
        bus.is_branch = br; bus.is_link = link; bus.set_flags = sf;
        bus.mem_ready = 1'b1; bus.halt = 1'b1;   // ignored outside MEM/WB
        exp_q.push_back(mk(3'd1, 9'b100000000));
        cycle_begin();
        bus.mem_ready = 1'b0; bus.halt = 1'b0;
        exp_q.push_back(mk(3'd2, 9'b010000000));
        if (mem && pass) begin
            for (int j = 1; j <= MAXW; j++) begin
                cycle_begin();
                bus.cond_field = ~cond; bus.cpsr = ~flags;   // must not matter after READ
                bus.mem_ready = (j == ready_at);
                exp_q.push_back(mk(3'd3, 9'b001000000));
                if (j == rst_at) begin
                    rst = 1'b1;
                    cycle_begin();
                    rst = 1'b0; bus.mem_ready = 1'b0;
                    m_ret = 0; m_ann = 0;
                    exp_q.push_back(mk(3'd0, 9'b0));
                    $display("TXN %s reset during MEM cycle %0d", nm, j);
                    return;
                end
                if (j == ready_at) break;
                if (j == MAXW) begin
                    for (int h = 0; h < 3; h++) begin
                        cycle_begin();
                        bus.mem_ready = (h == 1);
                        exp_q.push_back(mk(3'd6, 9'b000000001));
                    end
                    $display("TXN %s mem timeout -> ERR", nm);
                    return;
                end
            end
        end
        cycle_begin();
        bus.cond_field = cond; bus.cpsr = flags;
        bus.mem_ready = 1'b0; bus.halt = hlt;
        exp_q.push_back(mk(3'd4, {3'b000, pass & ~br, pass & sf, 1'b1, pass & br, pass & br & link, 1'b0}));
        if (pass) m_ret++; else m_ann++;
        if (hlt) begin
            for (int h = 0; h < 3; h++) begin
                cycle_begin();
                bus.halt = 1'b0;
                exp_q.push_back(mk(3'd5, 9'b0));
            end
        end
        $display("TXN %s cond=%h cpsr=%b mem=%0d br=%0d pass=%0d", nm, cond, flags, mem, br, pass);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pats [3];
        pats[0] = 4'b1010; pats[1] = 4'b0101; pats[2] = 4'b0110;
        rst = 1'b1;
        bus.halt = 0; bus.cond_field = 0; bus.cpsr = 0; bus.is_mem = 0;
        bus.is_branch = 0; bus.is_link = 0; bus.set_flags = 0; bus.mem_ready = 0;
        cycle_begin();
        exp_q.push_back(mk(3'd0, 9'b0));
        cycle_begin();
        exp_q.push_back(mk(3'd0, 9'b0));
        rst = 1'b0;

        do_instr("alu_s",  4'hE, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        do_instr("alu",    4'hE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        settle(); check_lit("alu_len", last_gap, 3);
        do_instr("eq_ann", 4'h0, 4'b0000, 0, 0, 0, 1, 0, 0, 0);
        settle(); check_lit("annul_len", last_gap, 3);
        do_instr("ldr_r3", 4'hE, 4'b0000, 1, 0, 0, 0, 3, 0, 0);
        settle(); check_lit("ldr3_len", last_gap, 6);
        check_lit("ldr3_mem_cycles", last_run, 3);
        do_instr("bl_gt",  4'hC, 4'b0000, 0, 1, 1, 0, 0, 0, 0);
        do_instr("bl_gtz", 4'hC, 4'b0100, 0, 1, 1, 0, 0, 0, 0);
        do_instr("ldr_ne", 4'h1, 4'b0100, 1, 0, 0, 0, 1, 0, 0);
        settle(); check_lit("ldr_annul_len", last_gap, 3);
        do_instr("ldr_r4", 4'hE, 4'b0000, 1, 0, 0, 0, 4, 0, 0);
        settle(); check_lit("ldr4_len", last_gap, 7);
        check_lit("ldr4_mem_cycles", last_run, 4);
        do_instr("nv",     4'hF, 4'b0100, 0, 0, 0, 1, 0, 0, 0);
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 16; c++)
                do_instr("cond_sweep", 4'(c), pats[p], 0, c[1], c[2], c[0], 0, 0, 0);
        do_instr("ldr_rst", 4'hE, 4'b0000, 1, 0, 0, 0, 0, 0, 2);
        do_instr("alu",     4'hE, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        do_instr("ldr_to",  4'hE, 4'b0000, 1, 0, 0, 0, 0, 0, 0);
        settle();
        check_lit("timeout_mem_cycles", last_run, 4);
        check_lit("mem_err_sticky", int'(bus.mem_err), 1);
        do_reset();
        do_instr("halt",   4'hE, 4'b0000, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        do_instr("bl_al",  4'hE, 4'b1111, 0, 1, 1, 1, 0, 0, 0);
        do_instr("ldr_r1", 4'hE, 4'b1111, 1, 0, 0, 0, 1, 0, 0);
        settle(); check_lit("ldr1_len", last_gap, 4);
        repeat (2) @(posedge clk);
        check_lit("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
